// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master (CPU / loader) arbiter for a single data memory port.
// Each transaction runs IDLE -> ACCESS -> RESP, giving a fixed ack latency of two
// cycles after the request is sampled. PRIO_MODE selects round-robin (0) or
// fixed m0-first (1).
// Optional bus locking is compiled in with macro DMEM_ARB_LOCK_EN, which adds
// the m0_lock / m1_lock inputs; without it, lock behaves as tied low.
module dmem_arbiter #(
  parameter int unsigned PRIO_MODE = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m0_we,
  input  logic [1:0]  m0_size,
`ifdef DMEM_ARB_LOCK_EN
  input  logic        m0_lock,
  input  logic        m1_lock,
`endif
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic        m1_we,
  input  logic [1:0]  m1_size,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_size,
  output logic        mem_re,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 2;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          we;
    logic [SW-1:0] size;
  } txn_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  txn_t          hold_q, hold_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          id_q, id_d;
  logic          ptr_q, ptr_d;
  logic          lock_act_q, lock_act_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;

  txn_t          m0_pkt_c, m1_pkt_c;
  logic          lock0_c, lock1_c;
  logic          elig0_c, elig1_c;
  logic          win_c;
  logic          access_c;

  // Lock inputs, tied low when the lock feature is not built
`ifdef DMEM_ARB_LOCK_EN
  assign lock0_c = m0_lock;
  assign lock1_c = m1_lock;
`else
  assign lock0_c = 1'b0;
  assign lock1_c = 1'b0;
`endif

  assign m0_pkt_c = {m0_addr, m0_wdata, m0_we, m0_size};
  assign m1_pkt_c = {m1_addr, m1_wdata, m1_we, m1_size};

  // While a lock is active only the current grantee is eligible
  assign elig0_c = m0_req && (!lock_act_q || !id_q);
  assign elig1_c = m1_req && (!lock_act_q || id_q);

  // Contention goes to m0 in fixed mode, else to the pointer; a lone requester always wins
  assign win_c = (elig0_c && elig1_c) ? ((PRIO_MODE != 0) ? 1'b0 : ptr_q) : !elig0_c;

  // Next-state and register-input decode
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    rdata_d    = rdata_q;
    id_d       = id_q;
    ptr_d      = ptr_q;
    lock_act_d = lock_act_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (elig0_c || elig1_c) begin
          id_d    = win_c;
          hold_d  = win_c ? m1_pkt_c : m0_pkt_c;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        rdata_d = mem_rdata;
        ack0_d  = !id_q;
        ack1_d  = id_q;
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
        if (id_q ? lock1_c : lock0_c) begin
          lock_act_d = 1'b1;
        end else begin
          lock_act_d = 1'b0;
          ptr_d      = !id_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and holding registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      rdata_q    <= '0;
      id_q       <= 1'b0;
      ptr_q      <= 1'b0;
      lock_act_q <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      rdata_q    <= rdata_d;
      id_q       <= id_d;
      ptr_q      <= ptr_d;
      lock_act_q <= lock_act_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
    end
  end

  // Memory strobes are gated by reset so an interrupted access never writes
  assign access_c  = (state_q == ACCESS);
  assign mem_re    = access_c && !hold_q.we && reset;
  assign mem_we    = access_c && hold_q.we && reset;
  assign mem_addr  = hold_q.addr;
  assign mem_wdata = hold_q.wdata;
  assign mem_size  = hold_q.size;

  assign m0_ack   = ack0_q;
  assign m1_ack   = ack1_q;
  assign m0_rdata = rdata_q;
  assign m1_rdata = rdata_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter PRIO_MODE, default 0; 0 = round-robin arbitration, 1 = fixed priority with m0 winning.
REQ-002 The block SHALL have port clock  input  1  single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 The block SHALL have ports mN_req  input  1  transaction request from master N (N = 0 CPU, N = 1 loader/DMA).
REQ-005 The block SHALL have ports mN_addr  input  32, mN_wdata  input  32, mN_we  input  1 and mN_size  input  2, giving the request attributes of master N.
REQ-006 The block SHALL have ports mN_ack  output  1  one-cycle completion strobe to master N, and mN_rdata  output  32  read data, valid while mN_ack is high.
REQ-007 The block SHALL have ports mem_addr  output  32, mem_wdata  output  32, mem_size  output  2, mem_re  output  1 and mem_we  output  1, which drive the data memory port.
REQ-008 The block SHALL have port mem_rdata  input  32  asynchronous read data returned by the data memory.
REQ-009 The block SHALL have port busy  output  1, high whenever the state is not IDLE.

Function
REQ-010 The block SHALL implement an FSM with states IDLE, ACCESS and RESP.
REQ-011 In IDLE with any mN_req high, the block SHALL select a winner, latch the winner's addr/wdata/we/size and winner id into holding registers, and go to ACCESS; with no request it SHALL stay in IDLE.
REQ-012 In ACCESS the block SHALL drive mem_* from the holding registers for exactly one cycle (mem_we = held we; mem_re = !held we), capture mem_rdata into the read register, and go to RESP.
REQ-013 In RESP the block SHALL pulse the winner's mN_ack for one cycle, present the captured read data on mN_rdata, and return to IDLE.
REQ-014 Latency SHALL be fixed: request sampled in IDLE at edge E, mem access during cycle E+1, ack during cycle E+2; minimum issue interval per request is 3 cycles.
REQ-015 Outside ACCESS, mem_re and mem_we SHALL be 0; mem_addr, mem_wdata and mem_size SHALL hold the last latched values.
REQ-016 A master SHALL hold mN_req and its attributes stable until its mN_ack; a req still high in the ack cycle counts as a new request at the next IDLE.
REQ-017 The loser's mN_ack SHALL remain 0, and the loser's request SHALL remain pending without loss.
REQ-018 With PRIO_MODE=0, a round-robin pointer SHALL name the preferred master; on each RESP the pointer SHALL be set to the master that did not win.
REQ-019 With PRIO_MODE=0 and both masters requesting, the preferred master SHALL win; with a single requester, that requester SHALL win regardless of the pointer.
REQ-020 With PRIO_MODE=1, m0 SHALL always win a simultaneous request; the pointer is unused.
REQ-021 mN_rdata for a write transaction SHALL be don't-care; mN_ack SHALL still pulse.
REQ-022 Attribute changes on the winner's inputs after latching SHALL have no effect on the transaction in flight.

Reset
REQ-023 While reset is low at a rising edge: state SHALL become IDLE, the pointer SHALL become m0, and the holding and read registers SHALL become 0.
REQ-024 All outputs SHALL be 0 after reset: mN_ack, mN_rdata, mem_*, busy.
REQ-025 mem_we and mem_re SHALL be combinationally forced to 0 while reset is low, so a reset during ACCESS performs no memory write.
REQ-026 A transaction interrupted by reset SHALL be abandoned, with no ack issued; the master SHALL re-request.

Configuration
REQ-027 With macro DMEM_ARB_LOCK_EN defined, ports m0_lock and m1_lock (input, 1) SHALL exist.
REQ-028 With DMEM_ARB_LOCK_EN defined, a winner whose lock is high at its RESP SHALL remain the exclusive grantee: other requests are ignored and the pointer is not updated until a RESP with lock low.
REQ-029 With DMEM_ARB_LOCK_EN undefined, the lock ports SHALL be absent and behaviour SHALL equal lock = 0.

Verification
REQ-030 Scenario: m0 read of addr 0x10000004, mem_rdata = 0xDEADBEEF -> mem_re high for exactly one cycle at E+1; m0_ack with m0_rdata = 0xDEADBEEF at E+2.
REQ-031 Scenario: PRIO_MODE=0, both masters req continuously from reset -> grant order m0, m1, m0, m1; acks spaced 3 cycles apart.
REQ-032 Scenario: PRIO_MODE=1, both masters req continuously -> only m0 is acked; m1 acked only after m0 drops req.
REQ-033 Scenario: m1 write of 0x12345678 to 0x7FFFFFFC, then m0 read of the same address -> mem_we pulses once with the latched data; m0_rdata = 0x12345678.
REQ-034 Scenario: reset low during an ACCESS write -> mem_we = 0 in that cycle; no ack; state, busy and outputs return to 0.
REQ-035 Scenario (DMEM_ARB_LOCK_EN): m1 lock high for 3 transactions while m0 requests -> three m1 acks, then m0 is granted.
